// File: rtl/cwe1234_lock_arbiter.sv
// Round-robin arbitrated write port for a 16-bit register guarded by a sticky lock FSM.
// Debug is reachable only from LOCKED, and entering it wipes the register.
module cwe1234_lock_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             resetn,
    input  logic             req_1,
    input  logic             req_2,
    input  logic [WIDTH-1:0] wdata_1,
    input  logic [WIDTH-1:0] wdata_2,
    output logic             ack_1,
    output logic             ack_2,
    output logic             err_1,
    output logic             err_2,
    input  logic             lock_req,
    input  logic             debug_req,
    input  logic             debug_exit,
    output logic             locked,
    output logic             debug_mode,
    output logic [WIDTH-1:0] Data_out,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam logic [1:0] ST_OPEN   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_DEBUG  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             prio_2;
    logic             elig_1_c;
    logic             elig_2_c;
    logic             grant_1_c;
    logic             grant_2_c;
    logic             grant_c;
    logic             commit_c;
    logic             reject_c;
    logic             wipe_c;
    logic [WIDTH-1:0] wdata_c;

    // A requester whose ack/err is showing is still holding req for the write just served.
    always_comb begin
        elig_1_c  = req_1 & ~ack_1 & ~err_1;
        elig_2_c  = req_2 & ~ack_2 & ~err_2;
        grant_1_c = elig_1_c & (~elig_2_c | ~prio_2);
        grant_2_c = elig_2_c & (~elig_1_c | prio_2);
        grant_c   = grant_1_c | grant_2_c;
        wdata_c   = grant_2_c ? wdata_2 : wdata_1;
    end

    // Next state plus write verdict, both judged against the current state.
    always_comb begin
        state_nx = state;
        commit_c = 1'b0;
        reject_c = 1'b0;
        wipe_c   = 1'b0;
        case (state)
            ST_OPEN: begin
                commit_c = grant_c;
                if (lock_req) state_nx = ST_LOCKED;
            end
            ST_LOCKED: begin
                reject_c = grant_c;
                if (debug_req) begin
                    state_nx = ST_DEBUG;
                    wipe_c   = 1'b1;
                end
            end
            ST_DEBUG: begin
                commit_c = grant_c;
                if (debug_exit) state_nx = ST_LOCKED;
            end
            default: state_nx = ST_LOCKED;
        endcase
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_OPEN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            prio_2     <= 1'b0;
            ack_1      <= 1'b0;
            ack_2      <= 1'b0;
            err_1      <= 1'b0;
            err_2      <= 1'b0;
            locked     <= 1'b0;
            debug_mode <= 1'b0;
            Data_out   <= '0;
            viol_cnt   <= '0;
        end else begin
            if (grant_c) prio_2 <= grant_1_c;
            ack_1      <= grant_1_c & commit_c;
            ack_2      <= grant_2_c & commit_c;
            err_1      <= grant_1_c & reject_c;
            err_2      <= grant_2_c & reject_c;
            locked     <= (state_nx != ST_OPEN);
            debug_mode <= (state_nx == ST_DEBUG);
            // The debug-entry wipe outranks any same-cycle write.
            if (wipe_c) begin
                Data_out <= '0;
            end else if (commit_c) begin
                Data_out <= wdata_c;
            end
            if (reject_c && !(&viol_cnt)) viol_cnt <= viol_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cwe1234_lock_arbiter.sv
// Directed vector table plus hand sequences for cwe1234_lock_arbiter.
module tb_cwe1234_lock_arbiter;

    logic        Clk = 1'b0;
    logic        resetn;
    logic        req_1, req_2;
    logic [15:0] wdata_1, wdata_2;
    logic        ack_1, ack_2, err_1, err_2;
    logic        lock_req, debug_req, debug_exit;
    logic        locked, debug_mode;
    logic [15:0] Data_out;
    logic [7:0]  viol_cnt;

    int checks   = 0;
    int failures = 0;

    cwe1234_lock_arbiter #(.WIDTH(16), .CNT_W(8)) dut (
        .Clk(Clk), .resetn(resetn),
        .req_1(req_1), .req_2(req_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
        .ack_1(ack_1), .ack_2(ack_2), .err_1(err_1), .err_2(err_2),
        .lock_req(lock_req), .debug_req(debug_req), .debug_exit(debug_exit),
        .locked(locked), .debug_mode(debug_mode),
        .Data_out(Data_out), .viol_cnt(viol_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        r1, r2;
        logic [15:0] wd1, wd2;
        logic        lk, dbg, dex;
        logic        a1, a2, e1, e2;
        logic        lkd, dm;
        logic [15:0] data;
        logic [7:0]  viol;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic r2, input logic [15:0] wd1,
                         input logic [15:0] wd2, input logic lk, input logic dbg, input logic dex);
        req_1 = r1; req_2 = r2; wdata_1 = wd1; wdata_2 = wd2;
        lock_req = lk; debug_req = dbg; debug_exit = dex;
    endtask

    task automatic check_all(input string tag, input logic a1, input logic a2, input logic e1,
                             input logic e2, input logic lkd, input logic dm,
                             input logic [15:0] data, input logic [7:0] viol);
        check({tag, ".ack_1"}, 32'(ack_1), 32'(a1));
        check({tag, ".ack_2"}, 32'(ack_2), 32'(a2));
        check({tag, ".err_1"}, 32'(err_1), 32'(e1));
        check({tag, ".err_2"}, 32'(err_2), 32'(e2));
        check({tag, ".locked"}, 32'(locked), 32'(lkd));
        check({tag, ".debug_mode"}, 32'(debug_mode), 32'(dm));
        check({tag, ".Data_out"}, 32'(Data_out), 32'(data));
        check({tag, ".viol_cnt"}, 32'(viol_cnt), 32'(viol));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        resetn = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        resetn = 1'b1;
    endtask

    initial begin
        int errs;
        //           r1 r2 wd1      wd2      lk dbg dex a1 a2 e1 e2 lkd dm data     viol
        vecs[0]  = '{1, 0, 16'hA5A5, 16'h0,    0, 0, 0, 1, 0, 0, 0, 0, 0, 16'hA5A5, 8'd0};
        vecs[1]  = '{0, 1, 16'h0,    16'h0BEE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0BEE, 8'd0};
        vecs[2]  = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h1111, 8'd0};
        vecs[3]  = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h2222, 8'd0};
        vecs[4]  = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h1111, 8'd0};
        vecs[5]  = '{1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h2222, 8'd0};
        vecs[6]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h2222, 8'd0};
        vecs[7]  = '{1, 0, 16'h3333, 16'h0,    1, 0, 0, 1, 0, 0, 0, 1, 0, 16'h3333, 8'd0};
        vecs[8]  = '{0, 1, 16'h0,    16'h4444, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h3333, 8'd1};
        vecs[9]  = '{0, 0, 16'h0,    16'h0,    0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h3333, 8'd1};
        vecs[10] = '{0, 0, 16'h0,    16'h0,    0, 1, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 8'd1};
        vecs[11] = '{1, 0, 16'h5555, 16'h0,    0, 0, 0, 1, 0, 0, 0, 1, 1, 16'h5555, 8'd1};
        vecs[12] = '{0, 0, 16'h0,    16'h0,    0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h5555, 8'd1};
        vecs[13] = '{0, 1, 16'h0,    16'h7777, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h5555, 8'd2};
        vecs[14] = '{1, 0, 16'h6666, 16'h0,    0, 1, 0, 0, 0, 1, 0, 1, 1, 16'h0000, 8'd3};
        vecs[15] = '{0, 1, 16'h0,    16'h8888, 0, 0, 1, 0, 1, 0, 0, 1, 0, 16'h8888, 8'd3};
        vecs[16] = '{0, 0, 16'h0,    16'h0,    1, 0, 1, 0, 0, 0, 0, 1, 0, 16'h8888, 8'd3};

        resetn = 1'b0;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        check_all("reset", 0, 0, 0, 0, 0, 0, 16'h0, 8'd0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge Clk);
            drive(vecs[i].r1, vecs[i].r2, vecs[i].wd1, vecs[i].wd2,
                  vecs[i].lk, vecs[i].dbg, vecs[i].dex);
            @(posedge Clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2,
                      vecs[i].lkd, vecs[i].dm, vecs[i].data, vecs[i].viol);
        end

        // 300 rejected writes while LOCKED: counter saturates, register untouched.
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            drive(1, 0, 16'(i), 16'h0, 0, 0, 0);
            @(posedge Clk);
            #1;
            if (err_1 === 1'b1 && ack_1 === 1'b0) errs++;
            @(negedge Clk);
            drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
            if (i == 99) check("sat.viol_mid", 32'(viol_cnt), 32'd103);
        end
        @(posedge Clk);
        #1;
        check("sat.err_pulses", 32'(errs), 32'd300);
        check("sat.viol_cnt", 32'(viol_cnt), 32'hFF);
        check("sat.Data_out", 32'(Data_out), 32'h8888);
        check("sat.locked", 32'(locked), 32'd1);

        // Fresh reset: debug_req while OPEN is ignored.
        do_reset();
        check_all("post_reset", 0, 0, 0, 0, 0, 0, 16'h0, 8'd0);
        @(negedge Clk);
        drive(1, 0, 16'h9999, 16'h0, 0, 1, 0);
        @(posedge Clk);
        #1;
        check_all("open_dbg_wr", 1, 0, 0, 0, 0, 0, 16'h9999, 8'd0);
        @(negedge Clk);
        drive(0, 0, 16'h0, 16'h0, 0, 1, 0);
        @(posedge Clk);
        #1;
        check_all("open_dbg_idle", 0, 0, 0, 0, 0, 0, 16'h9999, 8'd0);

        // Reset asserted while a grant is pending: async clear, no pulse.
        @(negedge Clk);
        drive(0, 1, 16'h0, 16'hABCD, 1, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 16'h0, 8'd0);
        @(posedge Clk);
        #1;
        check_all("rst_edge", 0, 0, 0, 0, 0, 0, 16'h0, 8'd0);
        @(negedge Clk);
        drive(0, 0, 16'h0, 16'h0, 0, 0, 0);
        resetn = 1'b1;
        @(negedge Clk);
        drive(1, 0, 16'h1357, 16'h0, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_all("after_rst_wr", 1, 0, 0, 0, 0, 0, 16'h1357, 8'd0);
        @(negedge Clk);
        drive(0, 0, 16'h0, 16'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
